trigger_driver: RTL and testbench

TRIGGER_DRIVER -- requirements
Module: trigger_driver

---
 rtl/trigger_driver.sv | 157 +++++++++++++++
 tb/tb_trigger_driver.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/trigger_driver.sv
// rtl/trigger_driver.sv - Timer or ECG-gated trigger pulse generator with burst counting,
// optional ECG delay and refractory holdoff.
module trigger_driver #(
   parameter int CNT_W       = 10,
   parameter int PERIOD_W    = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic [1:0]          mode,
   input  logic [PERIOD_W-1:0] period,
   input  logic [PERIOD_W-1:0] delay,
   input  logic [PERIOD_W-1:0] holdoff,
   input  logic [CNT_W-1:0]    burst_len,
   input  logic                ecg_sync,
   output logic                done,
   output logic [CNT_W-1:0]    count,
   output logic                busy,
   output logic                finished,
   output logic                missed
);
   localparam logic [1:0] MODE_TIMER   = 2'b00;
   localparam logic [1:0] MODE_ECG_DLY = 2'b10;
   localparam logic [1:0] MODE_RSVD    = 2'b11;

   typedef enum logic [2:0] {S_IDLE, S_ARM, S_DELAY, S_HOLDOFF, S_FINISH} state_t;
   state_t state, state_d;

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES:0]   warm_q;
   logic                   ecg_dly_q;
   logic                   ecg_edge_q;

   logic [1:0]          mode_q;
   logic [PERIOD_W-1:0] period_q, delay_q, holdoff_q;
   logic [CNT_W-1:0]    burst_q;
   logic [PERIOD_W-1:0] timer, timer_d;
   logic [PERIOD_W-1:0] period_eff;
   logic [CNT_W-1:0]    count_d, count_inc;
   logic                done_d, missed_d, fire, capture;

   // warm_q masks the edge that would otherwise appear while the chain fills after
   // reset with ecg_sync already high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q     <= '0;
         warm_q     <= '0;
         ecg_dly_q  <= 1'b0;
         ecg_edge_q <= 1'b0;
      end else begin
         sync_q     <= {sync_q[SYNC_STAGES-2:0], ecg_sync};
         warm_q     <= {warm_q[SYNC_STAGES-1:0], 1'b1};
         ecg_dly_q  <= sync_q[SYNC_STAGES-1];
         ecg_edge_q <= sync_q[SYNC_STAGES-1] & ~ecg_dly_q & warm_q[SYNC_STAGES];
      end
   end

   assign period_eff = (period_q < PERIOD_W'(2)) ? PERIOD_W'(2) : period_q;
   assign count_inc  = count + CNT_W'(1);
   assign capture    = (state == S_IDLE) && en;

   always_comb begin
      state_d  = state;
      timer_d  = timer;
      count_d  = count;
      done_d   = 1'b0;
      missed_d = missed;
      fire     = 1'b0;
      if (!en) begin
         state_d = S_IDLE;
         timer_d = '0;
         count_d = '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (mode != MODE_RSVD) begin
                  state_d  = S_ARM;
                  timer_d  = '0;
                  count_d  = '0;
                  missed_d = 1'b0;
               end
            end
            S_ARM: begin
               if (mode_q == MODE_TIMER) begin
                  if (timer == period_eff - PERIOD_W'(1)) fire = 1'b1;
                  else timer_d = timer + PERIOD_W'(1);
               end else if (ecg_edge_q) begin
                  if (mode_q == MODE_ECG_DLY && delay_q != '0) begin
                     state_d = S_DELAY;
                     timer_d = '0;
                  end else begin
                     fire = 1'b1;
                  end
               end
            end
            S_DELAY: begin
               if (ecg_edge_q) missed_d = 1'b1;
               if (timer == delay_q - PERIOD_W'(1)) fire = 1'b1;
               else timer_d = timer + PERIOD_W'(1);
            end
            S_HOLDOFF: begin
               if (ecg_edge_q) missed_d = 1'b1;
               if (timer == holdoff_q - PERIOD_W'(1)) begin
                  state_d = S_ARM;
                  timer_d = '0;
               end else begin
                  timer_d = timer + PERIOD_W'(1);
               end
            end
            S_FINISH: state_d = S_FINISH;
            default:  state_d = S_IDLE;
         endcase
         // Zero holdoff goes straight back to ARM so an edge during the done cycle is taken.
         if (fire) begin
            done_d  = 1'b1;
            count_d = count_inc;
            timer_d = '0;
            if (burst_q != '0 && count_inc == burst_q) state_d = S_FINISH;
            else if (mode_q == MODE_TIMER || holdoff_q == '0) state_d = S_ARM;
            else state_d = S_HOLDOFF;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         timer     <= '0;
         count     <= '0;
         done      <= 1'b0;
         missed    <= 1'b0;
         mode_q    <= '0;
         period_q  <= '0;
         delay_q   <= '0;
         holdoff_q <= '0;
         burst_q   <= '0;
      end else begin
         state  <= state_d;
         timer  <= timer_d;
         count  <= count_d;
         done   <= done_d;
         missed <= missed_d;
         if (capture) begin
            mode_q    <= mode;
            period_q  <= period;
            delay_q   <= delay;
            holdoff_q <= holdoff;
            burst_q   <= burst_len;
         end
      end
   end

   assign busy     = (state == S_ARM) || (state == S_DELAY) || (state == S_HOLDOFF);
   assign finished = (state == S_FINISH);

endmodule

// File: tb/tb_trigger_driver.sv
// tb/tb_trigger_driver.sv - Directed self-checking bench for trigger_driver.
module tb_trigger_driver;
   localparam int CNT_W    = 3;
   localparam int PERIOD_W = 32;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                en = 1'b0;
   logic                ecg_sync = 1'b0;
   logic [1:0]          mode = 2'b00;
   logic [PERIOD_W-1:0] period = '0;
   logic [PERIOD_W-1:0] delay = '0;
   logic [PERIOD_W-1:0] holdoff = '0;
   logic [CNT_W-1:0]    burst_len = '0;
   logic                done, busy, finished, missed;
   logic [CNT_W-1:0]    count;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   trigger_driver #(
      .CNT_W      (CNT_W),
      .PERIOD_W   (PERIOD_W),
      .SYNC_STAGES(2)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .mode     (mode),
      .period   (period),
      .delay    (delay),
      .holdoff  (holdoff),
      .burst_len(burst_len),
      .ecg_sync (ecg_sync),
      .done     (done),
      .count    (count),
      .busy     (busy),
      .finished (finished),
      .missed   (missed)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int nd;
      int first;

      #2;
      check("rst_done", done, 0);
      check("rst_count", count, 0);
      check("rst_busy", busy, 0);
      check("rst_finished", finished, 0);
      check("rst_missed", missed, 0);
      step(2);
      rst_n = 1'b1;
      step(2);

      // timer mode, period 5, burst of 3; later period change must be ignored
      mode = 2'b00; period = 5; burst_len = 3; en = 1'b1;
      step(1);
      check("t1_busy", busy, 1);
      period = 2;
      for (int i = 1; i <= 15; i++) begin
         step(1);
         check($sformatf("t1_done_%0d", i), done, (i % 5 == 0));
         if (i % 5 == 0) check($sformatf("t1_count_%0d", i), count, i / 5);
      end
      check("t1_finished", finished, 1);
      check("t1_busy_off", busy, 0);
      nd = 0;
      for (int i = 0; i < 10; i++) begin
         step(1);
         if (done) nd++;
      end
      check("t1_no_extra_done", nd, 0);
      check("t1_count_held", count, 3);
      en = 1'b0;
      step(1);
      check("t1_count_clr", count, 0);
      check("t1_finished_clr", finished, 0);

      // ECG immediate, holdoff 10, second edge during holdoff
      mode = 2'b01; holdoff = 10; burst_len = 0; en = 1'b1;
      step(1);
      ecg_sync = 1'b1;
      step(1);
      step(1);
      ecg_sync = 1'b0;
      step(1);
      check("t2_done_early", done, 0);
      step(1);
      check("t2_done_lat3", done, 1);
      check("t2_count", count, 1);
      ecg_sync = 1'b1;
      step(2);
      ecg_sync = 1'b0;
      step(3);
      check("t2_missed", missed, 1);
      check("t2_count_stays", count, 1);
      step(10);
      check("t2_count_after_ho", count, 1);
      check("t2_busy_arm", busy, 1);
      en = 1'b0;
      step(1);
      check("t2_missed_held", missed, 1);
      check("t2_count_clr", count, 0);
      check("t2_busy_clr", busy, 0);

      // ECG delayed by 20, edge every 50 cycles, unlimited burst
      mode = 2'b10; delay = 20; holdoff = 5; burst_len = 0; en = 1'b1;
      step(1);
      check("t3_missed_clr", missed, 0);
      for (int k = 1; k <= 3; k++) begin
         ecg_sync = 1'b1;
         first = -1;
         nd = 0;
         for (int j = 0; j < 50; j++) begin
            step(1);
            if (j == 2) ecg_sync = 1'b0;
            if (done) begin
               nd++;
               if (first < 0) first = j;
            end
         end
         check($sformatf("t3_lat_%0d", k), first, 23);
         check($sformatf("t3_ndone_%0d", k), nd, 1);
         check($sformatf("t3_count_%0d", k), count, k);
      end
      check("t3_missed", missed, 0);

      // timer mode period 0 behaves as 2; 3-bit count wraps
      en = 1'b0;
      step(1);
      mode = 2'b00; period = 0; burst_len = 0; en = 1'b1;
      step(1);
      for (int i = 1; i <= 16; i++) begin
         step(1);
         check($sformatf("t4_done_%0d", i), done, (i % 2 == 0));
         check($sformatf("t4_count_%0d", i), count, (i / 2) % 8);
      end

      // en dropped on the cycle a delayed trigger would fire
      en = 1'b0;
      step(1);
      mode = 2'b10; delay = 5; holdoff = 0; burst_len = 0; en = 1'b1;
      step(1);
      ecg_sync = 1'b1;
      step(1);
      step(1);
      ecg_sync = 1'b0;
      step(6);
      check("t5_done_pre", done, 0);
      check("t5_busy_delay", busy, 1);
      en = 1'b0;
      step(1);
      check("t5_done_blocked", done, 0);
      check("t5_count", count, 0);
      check("t5_busy", busy, 0);
      check("t5_finished", finished, 0);
      step(3);
      check("t5_done_late", done, 0);

      // reset during holdoff with ecg_sync held high
      mode = 2'b01; holdoff = 30; burst_len = 0; en = 1'b1;
      step(1);
      ecg_sync = 1'b1;
      step(1);
      step(3);
      check("t6_done", done, 1);
      check("t6_count", count, 1);
      step(5);
      check("t6_busy_ho", busy, 1);
      rst_n = 1'b0;
      #2;
      check("t6_rst_done", done, 0);
      check("t6_rst_count", count, 0);
      check("t6_rst_busy", busy, 0);
      check("t6_rst_finished", finished, 0);
      check("t6_rst_missed", missed, 0);
      step(2);
      rst_n = 1'b1;
      nd = 0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (done) nd++;
      end
      check("t6_no_false_edge", nd, 0);
      check("t6_count_post", count, 0);
      check("t6_busy_arm", busy, 1);
      ecg_sync = 1'b0;
      step(3);
      ecg_sync = 1'b1;
      first = -1;
      for (int j = 0; j < 10; j++) begin
         step(1);
         if (done && first < 0) first = j;
      end
      check("t6_fresh_edge_lat", first, 3);
      check("t6_fresh_count", count, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
